// File: rtl/jb_ul_dfe_cfg_sched.sv
// UL DFE shadow/active config scheduler: regmap writes go to shadow regs, and a commit copies
// them to the active regs in one edge on the next sync strobe. Optional: JB_UL_DFE_SCHED_TIMEOUT_EN.
module jb_ul_dfe_cfg_sched #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 61440
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_wr_en,
  input  logic [7:0]            i_cfg_addr,
  input  logic [31:0]           i_cfg_wdata,
  input  logic                  i_commit_req,
  input  logic                  i_sync_strb,
  output logic                  o_busy,
  output logic                  o_wr_drop,
  output logic                  o_commit_done,
  output logic                  o_commit_err,
  output logic [1:0][31:0]      o_car_nco_lsb,
  output logic [1:0][6:0]       o_car_nco_msb,
  output logic [1:0]            o_car_nco_sign,
  output logic [1:0][7:0]       o_str_gain_sign,
  output logic [1:0][7:0][3:0]  o_str_gain_scaler,
  output logic [1:0][7:0][15:0] o_str_gain_frac,
  output logic [7:0]            o_ant_gain_sign,
  output logic [7:0][3:0]       o_ant_gain_scaler,
  output logic [7:0][15:0]      o_ant_gain_frac,
  output logic [1:0][7:0][6:0]  o_ul_int_delay,
  output logic [1:0][7:0][15:0] o_ul_frac_delay,
  output logic                  o_ul_ant_int_frac_delay_trig
);

  typedef struct packed {
    logic [1:0][31:0]      nco_lsb;
    logic [1:0][6:0]       nco_msb;
    logic [1:0]            nco_sign;
    logic [1:0][7:0]       sg_sign;
    logic [1:0][7:0][3:0]  sg_scaler;
    logic [1:0][7:0][15:0] sg_frac;
    logic [7:0]            ag_sign;
    logic [7:0][3:0]       ag_scaler;
    logic [7:0][15:0]      ag_frac;
    logic [1:0][7:0][6:0]  int_dly;
    logic [1:0][7:0][15:0] frac_dly;
  } cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE} state_t;

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_trig, w_trig_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_drop;
  logic        w_load;
  cfg_t        r_shd, r_act;

  logic [3:0]  w_hi;
  logic [3:0]  w_lo;
  logic        w_hit;
  logic        w_wr_ok;

  assign o_busy = (r_state != S_IDLE);
  assign w_hi   = i_cfg_addr[7:4];
  assign w_lo   = i_cfg_addr[3:0];
  assign w_hit  = ((w_hi == 4'h0) && (w_lo[3:2] == 2'b00)) || (w_hi == 4'h1) ||
                  ((w_hi == 4'h2) && !w_lo[3]) || (w_hi == 4'h3);
  assign w_wr_ok = i_cfg_wr_en && w_hit && !o_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= i_cfg_wr_en && !w_wr_ok;
      if (w_wr_ok) begin
        case (w_hi)
          4'h0: begin
            if (w_lo[1]) begin
              r_shd.nco_sign[w_lo[0]] <= i_cfg_wdata[7];
              r_shd.nco_msb[w_lo[0]]  <= i_cfg_wdata[6:0];
            end else begin
              r_shd.nco_lsb[w_lo[0]]  <= i_cfg_wdata;
            end
          end
          4'h1: begin
            r_shd.sg_sign[w_lo[3]][w_lo[2:0]]   <= i_cfg_wdata[20];
            r_shd.sg_scaler[w_lo[3]][w_lo[2:0]] <= i_cfg_wdata[19:16];
            r_shd.sg_frac[w_lo[3]][w_lo[2:0]]   <= i_cfg_wdata[15:0];
          end
          4'h2: begin
            r_shd.ag_sign[w_lo[2:0]]   <= i_cfg_wdata[20];
            r_shd.ag_scaler[w_lo[2:0]] <= i_cfg_wdata[19:16];
            r_shd.ag_frac[w_lo[2:0]]   <= i_cfg_wdata[15:0];
          end
          4'h3: begin
            r_shd.int_dly[w_lo[3]][w_lo[2:0]]  <= i_cfg_wdata[22:16];
            r_shd.frac_dly[w_lo[3]][w_lo[2:0]] <= i_cfg_wdata[15:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JB_UL_DFE_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_wcnt;

  // Held at 0 outside ARMED, so the first ARMED cycle sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_wcnt <= '0;
    else if (r_state != S_ARMED) r_wcnt <= '0;
    else                        r_wcnt <= r_wcnt + 16'd1;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_trig_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_commit_req) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (i_sync_strb) begin
          w_load      = 1'b1;
          w_trig_nxt  = 1'b1;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = S_SETTLE;
        end
`ifdef JB_UL_DFE_SCHED_TIMEOUT_EN
        else if (r_wcnt == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_SETTLE: begin
        if (r_cnt == 16'd0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_act   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_trig_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_load) r_act <= r_shd;
    end
  end

  assign o_wr_drop                    = r_drop;
  assign o_commit_done                = r_done;
  assign o_commit_err                 = r_err;
  assign o_ul_ant_int_frac_delay_trig = r_trig;
  assign o_car_nco_lsb                = r_act.nco_lsb;
  assign o_car_nco_msb                = r_act.nco_msb;
  assign o_car_nco_sign               = r_act.nco_sign;
  assign o_str_gain_sign              = r_act.sg_sign;
  assign o_str_gain_scaler            = r_act.sg_scaler;
  assign o_str_gain_frac              = r_act.sg_frac;
  assign o_ant_gain_sign              = r_act.ag_sign;
  assign o_ant_gain_scaler            = r_act.ag_scaler;
  assign o_ant_gain_frac              = r_act.ag_frac;
  assign o_ul_int_delay               = r_act.int_dly;
  assign o_ul_frac_delay              = r_act.frac_dly;

endmodule

// File: tb/tb_jb_ul_dfe_cfg_sched.sv
// Directed bench for jb_ul_dfe_cfg_sched; timeout cases build only with JB_UL_DFE_SCHED_TIMEOUT_EN.
module tb_jb_ul_dfe_cfg_sched;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr_en = 1'b0;
  logic [7:0]            addr = '0;
  logic [31:0]           wdata = '0;
  logic                  req = 1'b0;
  logic                  sync = 1'b0;
  logic                  busy, drop, done, err, trig;
  logic [1:0][31:0]      nco_lsb;
  logic [1:0][6:0]       nco_msb;
  logic [1:0]            nco_sign;
  logic [1:0][7:0]       sg_sign;
  logic [1:0][7:0][3:0]  sg_scaler;
  logic [1:0][7:0][15:0] sg_frac;
  logic [7:0]            ag_sign;
  logic [7:0][3:0]       ag_scaler;
  logic [7:0][15:0]      ag_frac;
  logic [1:0][7:0][6:0]  int_dly;
  logic [1:0][7:0][15:0] frac_dly;

  int n_chk  = 0;
  int n_pass = 0;

  jb_ul_dfe_cfg_sched #(.SETTLE_CYC(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .i_cfg_wr_en(wr_en), .i_cfg_addr(addr), .i_cfg_wdata(wdata),
    .i_commit_req(req), .i_sync_strb(sync), .o_busy(busy), .o_wr_drop(drop),
    .o_commit_done(done), .o_commit_err(err),
    .o_car_nco_lsb(nco_lsb), .o_car_nco_msb(nco_msb), .o_car_nco_sign(nco_sign),
    .o_str_gain_sign(sg_sign), .o_str_gain_scaler(sg_scaler), .o_str_gain_frac(sg_frac),
    .o_ant_gain_sign(ag_sign), .o_ant_gain_scaler(ag_scaler), .o_ant_gain_frac(ag_frac),
    .o_ul_int_delay(int_dly), .o_ul_frac_delay(frac_dly), .o_ul_ant_int_frac_delay_trig(trig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic arm();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic strobe();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    logic seen;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_lsb", nco_lsb, 0);
    chk("rst_dly", {int_dly, frac_dly}, 0);
    chk("rst_pulses", {drop, done, err, trig}, 0);
    rst = 1'b0;
    tick();

    // NCO write + commit, trig/field timing, done at n+18
    wr(8'h00, 32'h1234_5678);
    chk("wr00_drop", drop, 0);
    wr(8'h02, 32'h0000_0085);
    arm();
    chk("armed_busy", busy, 1);
    tick(); tick();
    chk("armed_no_trig", {trig, nco_lsb[0]}, 0);
    strobe();
    chk("n1_trig", trig, 1);
    chk("n1_lsb", nco_lsb[0], 32'h1234_5678);
    chk("n1_msb", nco_msb[0], 7'h05);
    chk("n1_sign", nco_sign[0], 1);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("n2_trig", trig, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen |= done;
    end
    chk("done_early", seen, 0);
    tick();
    chk("n18_done", done, 1);
    chk("n18_busy", busy, 0);

    // write on the done cycle is accepted; ARMED write dropped
    wr(8'h20, 32'h0013_ABCD);
    chk("wr_done_cyc_drop", {drop, done, busy}, 0);
    arm();
    wr(8'h35, 32'h0041_8000);
    chk("armed_wr_drop", drop, 1);
    strobe();
    chk("dly_dropped", {int_dly[0][5], frac_dly[0][5]}, 0);
    chk("ag0", {ag_sign[0], ag_scaler[0], ag_frac[0]}, {1'b1, 4'h3, 16'hABCD});
    wait_done();
    tick();
    chk("req_in_settle_ign", busy, 0);
    wr(8'h35, 32'h0041_8000);
    chk("idle_wr_drop", drop, 0);
    arm();
    strobe();
    chk("int_dly05", int_dly[0][5], 7'h41);
    chk("frac_dly05", frac_dly[0][5], 16'h8000);
    wait_done();

    // unmapped writes; same-cycle commit_req/sync_strb
    wr(8'h50, 32'hFFFF_FFFF);
    chk("wr50_drop", drop, 1);
    wr(8'h04, 32'hFFFF_FFFF);
    chk("wr04_drop", drop, 1);
    wr(8'h1B, 32'h001A_5555);
    req = 1'b1; sync = 1'b1;
    tick();
    req = 1'b0; sync = 1'b0;
    chk("same_cyc_trig", trig, 0);
    chk("same_cyc_busy", busy, 1);
    tick();
    chk("same_cyc_sg_old", sg_frac[1][3], 0);
    strobe();
    chk("sync2_trig", trig, 1);
    chk("sg13", {sg_sign[1][3], sg_scaler[1][3], sg_frac[1][3]}, {1'b1, 4'hA, 16'h5555});
    chk("unmapped_no_chg", {nco_lsb[0], nco_lsb[1], nco_msb[1], ag_frac[4]},
        {32'h1234_5678, 32'h0, 7'h0, 16'h0});
    wait_done();

`ifdef JB_UL_DFE_SCHED_TIMEOUT_EN
    wr(8'h01, 32'hDEAD_BEEF);
    arm();
    seen = 1'b0;
    for (int i = 0; i < 99; i++) begin
      seen |= err | trig;
      tick();
    end
    chk("tmo_early", seen | err, 0);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_lsb1", {nco_lsb[1], trig}, 0);
    tick();
    chk("tmo_err_pulse", err, 0);
    arm();
    for (int i = 0; i < 99; i++) tick();
    strobe();
    chk("tmo_sync_wins", {trig, err}, 2'b10);
    chk("tmo_lsb1_new", nco_lsb[1], 32'hDEAD_BEEF);
    wait_done();
`else
    wr(8'h01, 32'hDEAD_BEEF);
    arm();
    for (int i = 0; i < 150; i++) tick();
    chk("no_tmo_busy", {busy, err}, 2'b10);
    strobe();
    chk("no_tmo_commit", nco_lsb[1], 32'hDEAD_BEEF);
    wait_done();
`endif

    // reset mid-SETTLE
    wr(8'h21, 32'h001F_0001);
    arm();
    strobe();
    chk("pre_rst_ag1", ag_frac[1], 16'h0001);
    tick(); tick(); tick();
    rst = 1'b1;
    #2;
    chk("mid_rst_fields", {nco_lsb, ag_frac[1], int_dly[0][5]}, 0);
    chk("mid_rst_busy", {busy, trig, done}, 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= done | busy;
    end
    chk("no_done_after_rst", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
